// File: rtl/key_onecold_scanner_if.sv
// Key scanner bus: raw active-low key lines in, debounced one-cold vector and flags out.
interface key_onecold_scanner_if #(
  parameter int unsigned SIZE = 2
);
  localparam int unsigned N = 2 ** SIZE;

  logic [N-1:0] key_n;
  logic [N-1:0] a_out;
  logic         strobe;
  logic         multi;

  // master drives the keys, slave is the scanner
  modport master (output key_n, input a_out, input strobe, input multi);
  modport slave  (input key_n, output a_out, output strobe, output multi);
endinterface

// File: rtl/key_onecold_scanner.sv
// Debounced single-key scanner: synchronizes raw active-low keys, accepts one stable key
// at a time and presents it as a one-cold vector with a press strobe and a multi-key flag.
module key_onecold_scanner #(
  parameter int unsigned SIZE       = 2,
  parameter int unsigned DEB_CYCLES = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  key_onecold_scanner_if.slave  bus
);

  localparam int unsigned N    = 2 ** SIZE;
  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);

  // cnt counts stable samples; the sample that makes it DEB_CYCLES is the accepting one
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);
  localparam logic [N-1:0]    AllOnes = '1;
  localparam logic [N-1:0]    NOne    = N'(1);

  typedef enum logic [1:0] {
    StIdle,
    StDebounce,
    StHeld,
    StRelease
  } state_e;

  state_e          state_q;
  logic [N-1:0]    sync_q;
  logic [N-1:0]    sk_q;
  logic [N-1:0]    cand_q;
  logic [N-1:0]    a_out_q;
  logic [CntW-1:0] cnt_q;
  logic            strobe_q;
  logic            multi_q;

  logic [N-1:0]    zeros;
  logic [N-1:0]    zeros_m1;
  logic            one_zero;
  logic            many_zero;
  logic            all_ones;

  // x & (x-1) clears the lowest set bit: nonzero remainder means two or more zeros in sk
  always_comb begin
    zeros     = ~sk_q;
    zeros_m1  = zeros - NOne;
    many_zero = |(zeros & zeros_m1);
    one_zero  = (|zeros) && !many_zero;
    all_ones  = (sk_q == AllOnes);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= AllOnes;
      sk_q   <= AllOnes;
    end else begin
      sync_q <= bus.key_n;
      sk_q   <= sync_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cand_q   <= AllOnes;
      cnt_q    <= '0;
      a_out_q  <= AllOnes;
      strobe_q <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      multi_q  <= many_zero;
      unique case (state_q)
        StIdle: begin
          if (one_zero) begin
            cand_q <= sk_q;
            if (DEB_CYCLES == 1) begin
              a_out_q  <= sk_q;
              strobe_q <= 1'b1;
              cnt_q    <= '0;
              state_q  <= StHeld;
            end else begin
              cnt_q   <= CntOne;
              state_q <= StDebounce;
            end
          end
        end
        StDebounce: begin
          if (sk_q != cand_q) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else if (cnt_q == CntLast) begin
            a_out_q  <= cand_q;
            strobe_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= StHeld;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StHeld: begin
          // a_out is frozen here; only a full release is of interest
          if (all_ones) begin
            if (DEB_CYCLES == 1) begin
              a_out_q <= AllOnes;
              cnt_q   <= '0;
              state_q <= StIdle;
            end else begin
              cnt_q   <= CntOne;
              state_q <= StRelease;
            end
          end
        end
        StRelease: begin
          if (!all_ones) begin
            cnt_q   <= '0;
            state_q <= StHeld;
          end else if (cnt_q == CntLast) begin
            a_out_q <= AllOnes;
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.a_out  = a_out_q;
  assign bus.strobe = strobe_q;
  assign bus.multi  = multi_q;

endmodule

// File: tb/tb_key_onecold_scanner.sv
// Bench for key_onecold_scanner (SIZE=2, DEB_CYCLES=4): segment table plus hand-written
// bounce sequence, expectations queued at drive time and checked after each rising edge.
module tb_key_onecold_scanner;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] key;
    int         len;
    logic [3:0] a_pre;
    logic [3:0] a_post;
    int         a_at;
    int         strb_at;
    logic       m_pre;
    logic       m_post;
    int         m_at;
  } seg_t;

  typedef struct {
    string      name;
    logic [3:0] a;
    logic       s;
    logic       m;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  key_onecold_scanner_if #(.SIZE(2)) bus ();

  key_onecold_scanner #(
    .SIZE       (2),
    .DEB_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  seg_t tbl_a[$];
  seg_t tbl_b[$];
  int   vectors      = 0;
  int   miscompares  = 0;
  int   exp_strobes  = 0;
  int   seen_strobes = 0;

  function automatic seg_t mk(input string name, input logic rst, input logic [3:0] key,
                              input int len, input logic [3:0] a_pre, input logic [3:0] a_post,
                              input int a_at, input int strb_at, input logic m_pre,
                              input logic m_post, input int m_at);
    seg_t s;
    s.name = name; s.rst = rst; s.key = key; s.len = len;
    s.a_pre = a_pre; s.a_post = a_post; s.a_at = a_at; s.strb_at = strb_at;
    s.m_pre = m_pre; s.m_post = m_post; s.m_at = m_at;
    return s;
  endfunction

  function automatic bit onecold_ok(input logic [3:0] v);
    int z = 0;
    for (int i = 0; i < 4; i++) if (v[i] === 1'b0) z++;
    return (v === 4'b1111) || (z == 1 && !$isunknown(v));
  endfunction

  task automatic step(input string name, input logic rst, input logic [3:0] key,
                      input logic [3:0] a, input logic s, input logic m);
    exp_t e;
    @(negedge clk);
    rst_n     = rst;
    bus.key_n = key;
    e.name = name; e.a = a; e.s = s; e.m = m;
    sb_q.push_back(e);
    if (s) exp_strobes++;
  endtask

  task automatic apply_seg(input seg_t sg);
    for (int j = 1; j <= sg.len; j++) begin
      step(sg.name, sg.rst, sg.key,
           (sg.a_at != 0 && j >= sg.a_at) ? sg.a_post : sg.a_pre,
           (j == sg.strb_at),
           (sg.m_at != 0 && j >= sg.m_at) ? sg.m_post : sg.m_pre);
    end
  endtask

  // Monitor: one expectation consumed per rising edge, sampled 1 time unit after it
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      vectors++;
      if (bus.a_out !== e.a) begin
        miscompares++;
        $display("FAIL %s a_out got %b want %b (t=%0t)", e.name, bus.a_out, e.a, $time);
      end
      if (bus.strobe !== e.s) begin
        miscompares++;
        $display("FAIL %s strobe got %b want %b (t=%0t)", e.name, bus.strobe, e.s, $time);
      end
      if (bus.multi !== e.m) begin
        miscompares++;
        $display("FAIL %s multi got %b want %b (t=%0t)", e.name, bus.multi, e.m, $time);
      end
      if (!onecold_ok(bus.a_out)) begin
        miscompares++;
        $display("FAIL %s a_out_legal got %b want all-ones or one zero", e.name, bus.a_out);
      end
      if (bus.strobe === 1'b1) seen_strobes++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    bus.key_n = 4'b1111;

    //              name          rst  key      len a_pre    a_post   a_at strb m_pre m_post m_at
    tbl_a.push_back(mk("reset",    0, 4'b1011,  2, 4'b1111, 4'b1111, 0, 0, 0, 0, 0));
    tbl_a.push_back(mk("press",    1, 4'b1011, 12, 4'b1111, 4'b1011, 6, 6, 0, 0, 0));
    tbl_a.push_back(mk("release",  1, 4'b1111, 10, 4'b1011, 4'b1111, 6, 0, 0, 0, 0));
    tbl_a.push_back(mk("glitch",   1, 4'b1011,  3, 4'b1111, 4'b1111, 0, 0, 0, 0, 0));
    tbl_a.push_back(mk("glitch_up",1, 4'b1111,  8, 4'b1111, 4'b1111, 0, 0, 0, 0, 0));
    tbl_a.push_back(mk("press2",   1, 4'b1011, 10, 4'b1111, 4'b1011, 6, 6, 0, 0, 0));

    tbl_b.push_back(mk("steady_rel",1, 4'b1111, 10, 4'b1011, 4'b1111, 6, 0, 0, 0, 0));
    tbl_b.push_back(mk("multi_idle",1, 4'b1001,  8, 4'b1111, 4'b1111, 0, 0, 0, 1, 3));
    tbl_b.push_back(mk("multi_off", 1, 4'b1111,  8, 4'b1111, 4'b1111, 0, 0, 1, 0, 3));
    tbl_b.push_back(mk("press3",    1, 4'b1011, 10, 4'b1111, 4'b1011, 6, 6, 0, 0, 0));
    tbl_b.push_back(mk("multi_held",1, 4'b0011,  8, 4'b1011, 4'b1011, 0, 0, 0, 1, 3));
    tbl_b.push_back(mk("other_key", 1, 4'b1101,  6, 4'b1011, 4'b1011, 0, 0, 1, 0, 3));
    tbl_b.push_back(mk("release3",  1, 4'b1111, 10, 4'b1011, 4'b1111, 6, 0, 0, 0, 0));
    tbl_b.push_back(mk("rst_deb_a", 1, 4'b1011,  3, 4'b1111, 4'b1111, 0, 0, 0, 0, 0));
    tbl_b.push_back(mk("rst_deb",   0, 4'b1011,  2, 4'b1111, 4'b1111, 0, 0, 0, 0, 0));
    tbl_b.push_back(mk("press_rst", 1, 4'b1011, 10, 4'b1111, 4'b1011, 6, 6, 0, 0, 0));
    tbl_b.push_back(mk("rst_held",  0, 4'b1011,  1, 4'b1011, 4'b1111, 1, 0, 0, 0, 0));
    tbl_b.push_back(mk("idle_rst",  1, 4'b1111,  8, 4'b1111, 4'b1111, 0, 0, 0, 0, 0));
    tbl_b.push_back(mk("pre_strb",  1, 4'b1011,  5, 4'b1111, 4'b1111, 0, 0, 0, 0, 0));
    tbl_b.push_back(mk("rst_strb",  0, 4'b1011,  1, 4'b1111, 4'b1111, 0, 0, 0, 0, 0));
    tbl_b.push_back(mk("idle_rst2", 1, 4'b1111,  8, 4'b1111, 4'b1111, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      logic [3:0] k;
      k = 4'b1111;
      k[i] = 1'b0;
      tbl_b.push_back(mk($sformatf("sweep_press%0d", i), 1, k, 10, 4'b1111, k, 6, 6, 0, 0, 0));
      tbl_b.push_back(mk($sformatf("sweep_rel%0d", i), 1, 4'b1111, 10, k, 4'b1111, 6, 0,
                         0, 0, 0));
    end

    foreach (tbl_a[i]) apply_seg(tbl_a[i]);

    // Bouncing release: sk never stays all-ones for DEB_CYCLES samples
    for (int k = 1; k <= 8; k++) begin
      step("bounce", 1'b1, (k % 2 == 1) ? 4'b1111 : 4'b1011, 4'b1011, 1'b0, 1'b0);
    end

    foreach (tbl_b[i]) apply_seg(tbl_b[i]);

    @(posedge clk);
    #3;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain %0d expectations left, want 0", sb_q.size());
    end
    if (seen_strobes != exp_strobes) begin
      miscompares++;
      $display("FAIL strobe_total got %0d want %0d", seen_strobes, exp_strobes);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_onecold_scanner.md
KEY_ONECOLD_SCANNER -- requirements
Module: key_onecold_scanner

Interface
REQ-001 Parameter SIZE, default 2, SHALL set the key count N = 2**SIZE (legal range 1..5).
REQ-002 Parameter DEB_CYCLES, default 4, SHALL set the debounce length in clock cycles (legal range 1..65535).
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the synchronous, active-low reset.
REQ-005 Port key_n, input, N bits, SHALL carry raw asynchronous active-low key lines (0 = pressed).
REQ-006 Port a_out, output, N bits, registered, SHALL carry the debounced one-cold vector for the downstream one-cold-to-binary encoder: exactly one 0 while a key is accepted, otherwise all ones.
REQ-007 Port strobe, output, 1 bit, registered, SHALL give a one-cycle pulse per accepted press.
REQ-008 Port multi, output, 1 bit, registered, SHALL flag that the synchronized input has two or more zeros.

Function
REQ-009 key_n SHALL pass through a 2-flop synchronizer; the FSM and multi SHALL use only the second-stage value (sk).
REQ-010 multi SHALL equal 1 on the edge after sk contains two or more zeros, otherwise 0, in every state.
REQ-011 The FSM SHALL have four states: IDLE, DEBOUNCE, HELD, RELEASE.
REQ-012 IDLE: if sk has exactly one zero, the FSM SHALL load cand = sk, set cnt = 1 and go to DEBOUNCE; all-ones or multi-zero sk SHALL leave it in IDLE.
REQ-013 DEBOUNCE: if sk == cand and cnt == DEB_CYCLES, the FSM SHALL load a_out = cand, pulse strobe, and go to HELD; with DEB_CYCLES = 1 this happens directly from IDLE at the detection edge.
REQ-014 DEBOUNCE: if sk == cand and cnt < DEB_CYCLES, it SHALL increment cnt; if sk != cand, it SHALL return to IDLE with cnt = 0 and no strobe.
REQ-015 HELD: a_out SHALL stay constant; when sk is all ones, the FSM SHALL set cnt = 1 and go to RELEASE. Any other sk, including a different single key or multiple keys, SHALL be ignored.
REQ-016 RELEASE: while sk is all ones, cnt SHALL increment; on the edge where cnt reaches DEB_CYCLES with sk all ones, a_out SHALL become all ones and the FSM SHALL go to IDLE. Any non-all-ones sk SHALL return the FSM to HELD with a_out unchanged.
REQ-017 Press latency: with raw key_n stable from edge 1, a_out and strobe SHALL update at edge DEB_CYCLES+2. Release latency SHALL be the same.
REQ-018 strobe SHALL be high for exactly one cycle per IDLE->HELD acceptance and never at any other time. Each accepted press SHALL produce exactly one release before the next acceptance.
REQ-019 cnt SHALL be sized as clog2(DEB_CYCLES+1) bits and SHALL never wrap.
REQ-020 a_out SHALL always be either all ones or a vector with exactly one zero; there SHALL be no intermediate values.

Reset
REQ-021 On any edge with rst_n = 0, in any state: both synchronizer stages and cand SHALL become all ones, cnt = 0, state = IDLE, a_out = all ones, strobe = 0, multi = 0.
REQ-022 Reset SHALL override all other behaviour, including a strobe due on the same edge; after release the first press SHALL need a full DEB_CYCLES+2 edges.

Verification (SIZE=2, DEB_CYCLES=4)
REQ-023 Reset: rst_n=0 for 2 edges, key_n=4'b1011 -> a_out=4'b1111, strobe=0, multi=0; after rst_n=1, the press is accepted at edge 6 counted from reset release.
REQ-024 Clean press: key_n=4'b1011 from edge 1, held 12 edges -> a_out=4'b1011 and strobe=1 at edge 6 only; strobe=0 at edges 7..12.
REQ-025 Glitch and bounce: key_n=4'b1011 for edges 1-3, then 4'b1111 -> no strobe, a_out stays 4'b1111. Held key, then release with key_n alternating 4'b1111/4'b1011 every edge -> a_out stays 4'b1011; then steady 4'b1111 -> a_out=4'b1111 at edge 6 after the steady release.
REQ-026 Multi-key: key_n=4'b1001 -> multi=1 from edge 3, no strobe, a_out=4'b1111. In HELD (4'b1011), key_n=4'b0011 -> a_out stays 4'b1011, multi=1.
REQ-027 Reset mid-operation: rst_n=0 at edge 4 of a press (DEBOUNCE) -> no strobe; rst_n=0 in HELD -> a_out=4'b1111 at that edge.
REQ-028 Sweep: each single key i=0..3 pressed and released in turn -> exactly 4 strobes, each a_out = all ones with bit i cleared.
